syntax_symbol_encoder: RTL and testbench

Encoder-side inverse of the decoder's symbol mapper. It takes a syntax element (QP, motion vector, binary flag, custom format) plus its context and produces the 4-bit ANS symbol that the decoder maps back to that element. It sits between the syntax generator and the ANS encoder core. The path is a 2-stage valid/ready pipeline that flags unmappable elements and keeps a saturating error count.

---
 rtl/ans_codec_pkg.sv | 23 ++
 rtl/syntax_symbol_inverse_map.sv | 58 +++++
 rtl/syntax_symbol_encoder.sv | 98 +++++++++
 tb/tb_syntax_symbol_encoder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ans_codec_pkg.sv
// Shared ANS codec constants and beat type, used by both the encoder-side
// inverse mapper and the decoder-side symbol mapper.
package ans_codec_pkg;

    localparam int CTX_QP     = 0;
    localparam int CTX_MV     = 1;
    localparam int CTX_FLAG   = 2;
    localparam int CTX_CUSTOM = 3;

    localparam int MV_SHIFT     = 2;
    localparam int CUSTOM_SHIFT = 4;

    localparam int SYM_W = 4;
    localparam int CTX_W = 4;

    typedef struct packed {
        logic [SYM_W-1:0] symbol;
        logic [CTX_W-1:0] ctx;
        logic             last;
        logic             err;
    } enc_beat_t;

endpackage

// File: rtl/syntax_symbol_inverse_map.sv
// Combinational element+context -> symbol+err mapping; exact inverse of the
// decoder's forward mapper for every representable element.
module syntax_symbol_inverse_map
    import ans_codec_pkg::*;
#(
    parameter int SYMBOL_WIDTH  = 4,
    parameter int CONTEXT_WIDTH = 4,
    parameter int SYNTAX_WIDTH  = 16
) (
    input  logic [SYNTAX_WIDTH-1:0]  elem,
    input  logic [CONTEXT_WIDTH-1:0] ctx,
    output logic [SYMBOL_WIDTH-1:0]  symbol,
    output logic                     err
);

    localparam logic [SYNTAX_WIDTH-1:0] MV_LOW = SYNTAX_WIDTH'((1 << MV_SHIFT) - 1);
    localparam logic [SYNTAX_WIDTH-1:0] CU_LOW = SYNTAX_WIDTH'((1 << CUSTOM_SHIFT) - 1);

    logic [SYNTAX_WIDTH-1:0] sh_mv;
    logic [SYNTAX_WIDTH-1:0] sh_cu;

    assign sh_mv = elem >> MV_SHIFT;
    assign sh_cu = elem >> CUSTOM_SHIFT;

    always_comb begin
        symbol = '0;
        err    = 1'b0;
        case (int'(ctx))
            CTX_QP: begin
                symbol = elem[SYMBOL_WIDTH-1:0];
                err    = (elem >> SYMBOL_WIDTH) != '0;
            end
            CTX_MV: begin
                symbol = sh_mv[SYMBOL_WIDTH-1:0];
                err    = ((elem & MV_LOW) != '0) || ((sh_mv >> SYMBOL_WIDTH) != '0);
            end
            CTX_FLAG: begin
                // Flag is inverted: element 1 is symbol 0, element 0 is canonical nonzero
                if (elem == SYNTAX_WIDTH'(1))
                    symbol = '0;
                else if (elem == '0)
                    symbol = SYMBOL_WIDTH'(1);
                else
                    err = 1'b1;
            end
            CTX_CUSTOM: begin
                symbol = sh_cu[SYMBOL_WIDTH-1:0];
                err    = ((elem & CU_LOW) != '0) || ((sh_cu >> SYMBOL_WIDTH) != '0);
            end
            default: begin
                err = elem != '1;
            end
        endcase
        if (err)
            symbol = '0;
    end

endmodule

// File: rtl/syntax_symbol_encoder.sv
// Two-stage valid/ready pipeline mapping syntax elements to ANS symbols,
// flagging unmappable elements and counting them with saturation.
module syntax_symbol_encoder
    import ans_codec_pkg::*;
#(
    parameter int SYMBOL_WIDTH  = 4,
    parameter int CONTEXT_WIDTH = 4,
    parameter int SYNTAX_WIDTH  = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SYNTAX_WIDTH-1:0]  in_elem,
    input  logic [CONTEXT_WIDTH-1:0] in_ctx,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SYMBOL_WIDTH-1:0]  out_symbol,
    output logic [CONTEXT_WIDTH-1:0] out_ctx,
    output logic                     out_last,
    output logic                     out_err,
    input  logic                     err_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef struct packed {
        logic [SYMBOL_WIDTH-1:0]  symbol;
        logic [CONTEXT_WIDTH-1:0] ctx;
        logic                     last;
        logic                     err;
    } beat_t;

    // vld_pipe[0]: stage A (input reg), vld_pipe[1]: stage B (output reg)
    logic [1:0]               vld_pipe;
    logic                     a_ready;
    logic                     b_ready;
    logic [SYNTAX_WIDTH-1:0]  a_elem;
    logic [CONTEXT_WIDTH-1:0] a_ctx;
    logic                     a_last;
    logic [SYMBOL_WIDTH-1:0]  m_symbol;
    logic                     m_err;
    beat_t                    b_q;
    logic                     hs_err;

    assign b_ready    = !vld_pipe[1] || out_ready;
    assign a_ready    = !vld_pipe[0] || b_ready;
    assign in_ready   = a_ready;
    assign out_valid  = vld_pipe[1];
    assign out_symbol = b_q.symbol;
    assign out_ctx    = b_q.ctx;
    assign out_last   = b_q.last;
    assign out_err    = b_q.err;
    assign hs_err     = vld_pipe[1] && out_ready && b_q.err;

    syntax_symbol_inverse_map #(
        .SYMBOL_WIDTH (SYMBOL_WIDTH),
        .CONTEXT_WIDTH(CONTEXT_WIDTH),
        .SYNTAX_WIDTH (SYNTAX_WIDTH)
    ) u_map (
        .elem  (a_elem),
        .ctx   (a_ctx),
        .symbol(m_symbol),
        .err   (m_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            a_elem    <= '0;
            a_ctx     <= '0;
            a_last    <= 1'b0;
            b_q       <= '0;
            err_count <= '0;
        end else begin
            if (a_ready) begin
                vld_pipe[0] <= in_valid;
                if (in_valid) begin
                    a_elem <= in_elem;
                    a_ctx  <= in_ctx;
                    a_last <= in_last;
                end
            end
            if (b_ready) begin
                vld_pipe[1] <= vld_pipe[0];
                if (vld_pipe[0])
                    b_q <= '{symbol: m_symbol, ctx: a_ctx, last: a_last, err: m_err};
            end
            // Clear wins over the old value but still counts a coincident error
            if (err_clr)
                err_count <= hs_err ? ERR_CNT_WIDTH'(1) : '0;
            else if (hs_err && err_count != '1)
                err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_syntax_symbol_encoder.sv
// Scoreboard bench for syntax_symbol_encoder; a second instance with a 3-bit
// error counter covers saturation.
module tb_syntax_symbol_encoder;
    import ans_codec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] in_elem = '0;
    logic [3:0]  in_ctx = '0;

    logic        in_ready, out_valid, out_last, out_err;
    logic [3:0]  out_symbol, out_ctx;
    logic [15:0] err_count;

    logic        s_in_ready, s_out_valid, s_out_last, s_out_err;
    logic [3:0]  s_out_symbol, s_out_ctx;
    logic [2:0]  s_err_count;

    int checks = 0;
    int errors = 0;
    int n_out = 0;
    enc_beat_t exp_q[$];
    enc_beat_t held;
    logic      held_v = 1'b0;
    logic      bp_mode = 1'b0;
    int        bp_idx = 0;

    always #5 clk = ~clk;

    syntax_symbol_encoder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_elem(in_elem), .in_ctx(in_ctx), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_symbol(out_symbol),
        .out_ctx(out_ctx), .out_last(out_last), .out_err(out_err),
        .err_clr(err_clr), .err_count(err_count)
    );

    syntax_symbol_encoder #(.ERR_CNT_WIDTH(3)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_elem(in_elem), .in_ctx(in_ctx), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_symbol(s_out_symbol),
        .out_ctx(s_out_ctx), .out_last(s_out_last), .out_err(s_out_err),
        .err_clr(err_clr), .err_count(s_err_count)
    );

    // Output monitor: pops the scoreboard on each handshake, checks stall stability
    always @(negedge clk) begin : mon
        enc_beat_t got;
        enc_beat_t exp;
        if (rst) begin
            held_v = 1'b0;
        end else if (out_valid) begin
            got = '{symbol: out_symbol, ctx: out_ctx, last: out_last, err: out_err};
            if (held_v) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %h, held %h", got, held);
                end
            end
            if (out_ready) begin
                held_v = 1'b0;
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got sym=%0d ctx=%0d last=%0b err=%0b",
                             got.symbol, got.ctx, got.last, got.err);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL beat: got sym=%0d ctx=%0d last=%0b err=%0b, exp sym=%0d ctx=%0d last=%0b err=%0b",
                                 got.symbol, got.ctx, got.last, got.err,
                                 exp.symbol, exp.ctx, exp.last, exp.err);
                    end
                end
            end else begin
                held   = got;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // out_ready pattern 1,0,0,1 while bp_mode is set
    always @(posedge clk) begin
        if (bp_mode) begin
            #1;
            out_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
            bp_idx++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input logic [15:0] e, input logic [3:0] c, input logic l,
                        input logic [3:0] es, input logic ee);
        int guard = 0;
        in_valid = 1'b1;
        in_elem  = e;
        in_ctx   = c;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b, need 1", in_ready);
        end else begin
            exp_q.push_back('{symbol: es, ctx: c, last: l, err: ee});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d, need 0", exp_q.size());
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, need 0", out_valid); end
        checks++;
        if ({out_symbol, out_ctx, out_last, out_err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h, need 0", {out_symbol, out_ctx, out_last, out_err});
        end
        checks++;
        if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d, need 0", err_count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, need 1", in_ready); end
    endtask

    task automatic test_round_trip();
        logic [15:0] e;
        logic [3:0]  s;
        out_ready = 1'b1;
        send(16'h0000, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid=%0b, need 0", out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_arrive: out_valid=%0b, need 1", out_valid); end
        for (int c = 0; c < 4; c++) begin
            for (int sym = 0; sym < 16; sym++) begin
                if (c == 0 && sym == 0) continue;
                case (c)
                    0: e = 16'(sym);
                    1: e = 16'(sym * 4);
                    2: e = (sym == 0) ? 16'd1 : 16'd0;
                    default: e = 16'(sym * 16);
                endcase
                s = (c == 2) ? ((sym == 0) ? 4'd0 : 4'd1) : 4'(sym);
                send(e, 4'(c), 1'b0, s, 1'b0);
            end
        end
        wait_drain();
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        pulse_clr();
        send(16'h0003, 4'd1, 1'b0, 4'd0, 1'b1);
        send(16'h0105, 4'd3, 1'b0, 4'd0, 1'b1);
        send(16'h0010, 4'd0, 1'b0, 4'd0, 1'b1);
        send(16'hFFFF, 4'd7, 1'b1, 4'd0, 1'b0);
        wait_drain();
        checks++;
        if (err_count !== 16'd3) begin errors++; $display("FAIL err_count_3: got %0d, need 3", err_count); end
    endtask

    task automatic test_backpressure();
        int start;
        start = n_out;
        out_ready = 1'b0;
        send(16'h0003, 4'd0, 1'b0, 4'd3, 1'b0);
        send(16'h0010, 4'd3, 1'b0, 4'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: in_ready=%0b out_valid=%0b, need 0/1", in_ready, out_valid);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        bp_idx  = 0;
        bp_mode = 1'b1;
        for (int i = 2; i < 8; i++) begin
            if (i == 5) send(16'h0001, 4'd1, 1'b0, 4'd0, 1'b1);
            else        send(16'(i * 16), 4'd3, i == 7, 4'(i), 1'b0);
        end
        wait_drain();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        checks++;
        if (n_out - start !== 8) begin errors++; $display("FAIL bp_count: got %0d beats, need 8", n_out - start); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) send(16'(i), 4'd0, i == 15, 4'(i), 1'b0);
            end
            begin
                int g = 0;
                @(negedge clk);
                while (!out_valid && g < 50) begin @(negedge clk); g++; end
                for (int i = 0; i < 16; i++) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_last !== 1'(i == 15)) begin
                        errors++;
                        $display("FAIL stream_beat%0d: valid=%0b last=%0b, need 1/%0b", i, out_valid, out_last, i == 15);
                    end
                    @(negedge clk);
                end
            end
        join
        wait_drain();
    endtask

    task automatic test_counter();
        out_ready = 1'b1;
        pulse_clr();
        for (int i = 0; i < 9; i++) send(16'h0100, 4'd0, 1'b0, 4'd0, 1'b1);
        wait_drain();
        checks++;
        if (s_err_count !== 3'd7) begin errors++; $display("FAIL sat_count: got %0d, need 7", s_err_count); end
        checks++;
        if (err_count !== 16'd9) begin errors++; $display("FAIL wide_count: got %0d, need 9", err_count); end
        out_ready = 1'b0;
        send(16'h0020, 4'd0, 1'b0, 4'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        err_clr   = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++;
        if (err_count !== 16'd1 || s_err_count !== 3'd1) begin
            errors++;
            $display("FAIL clr_with_err: got %0d/%0d, need 1/1", err_count, s_err_count);
        end
        pulse_clr();
        checks++;
        if (err_count !== 16'd0 || s_err_count !== 3'd0) begin
            errors++;
            $display("FAIL clr_alone: got %0d/%0d, need 0/0", err_count, s_err_count);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(16'h0100, 4'd0, 1'b0, 4'd0, 1'b1);
        wait_drain();
        checks++;
        if (err_count !== 16'd1) begin errors++; $display("FAIL pre_reset_count: got %0d, need 1", err_count); end
        out_ready = 1'b0;
        send(16'h0005, 4'd0, 1'b0, 4'd5, 1'b0);
        send(16'h0006, 4'd0, 1'b0, 4'd6, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %0b, need 0", out_valid); end
        checks++;
        if (err_count !== 16'd0 || s_err_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_count: got %0d/%0d, need 0/0", err_count, s_err_count);
        end
        out_ready = 1'b1;
        send(16'h0024, 4'd1, 1'b1, 4'd9, 1'b0);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_counter();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
